// File: rtl/load_store_unit.sv
// Load/store unit: takes one execute-stage op at a time, issues at most one data-memory
// request, and returns a single-cycle writeback pulse carrying either the result or an exception.
module load_store_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [1:0] EXC_MISALIGNED = 2'd0;
    localparam logic [1:0] EXC_TIMEOUT    = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL    = 2'd2;

    // The counter only has to reach MEM_TIMEOUT-1: the last WAIT cycle decides the timeout.
    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    off_q;
    logic [2:0]    funct3_q;
    logic          is_store_q;
    logic          rd_we_q;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_wstrb_q;
    logic          wb_valid_q, wb_we_q;
    logic [4:0]    wb_rd_q;
    logic [31:0]   wb_data_q;
    logic          exc_valid_q;
    logic [1:0]    exc_cause_q;
    logic [31:0]   exc_addr_q;

    logic          illegal_d, misaligned_d;
    logic [3:0]    wstrb_d;
    logic [31:0]   wdata_d;
    logic [7:0]    rbyte_d;
    logic [15:0]   rhalf_d;
    logic [31:0]   rdata_d;

    // Decode of the op presented at the input, used only on the accepting cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wstrb_d = 4'b1111;
        wdata_d = store_data;
        illegal_d = (is_load && is_store)
                 || (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                 || (is_store && funct3 >= 3'b011);
        misaligned_d = (is_load || is_store)
                    && ((funct3[1:0] == 2'b01 && alu_result[0])
                     || (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << alu_result[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_d = 4'b0011 << alu_result[1:0];
                wdata_d = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection and extension of returned load data.
    always_comb begin
        rbyte_d = mem_rdata[{off_q, 3'b000} +: 8];
        rhalf_d = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rdata_d = mem_rdata;
        case (funct3_q)
            3'b000:  rdata_d = {{24{rbyte_d[7]}}, rbyte_d};
            3'b100:  rdata_d = {24'd0, rbyte_d};
            3'b001:  rdata_d = {{16{rhalf_d[15]}}, rhalf_d};
            3'b101:  rdata_d = {16'd0, rhalf_d};
            default: rdata_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            is_store_q  <= 1'b0;
            rd_we_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        off_q      <= alu_result[1:0];
                        funct3_q   <= funct3;
                        is_store_q <= is_store;
                        rd_we_q    <= reg_we && (rd != 5'd0);
                        wb_rd_q    <= rd;
                        wb_data_q  <= alu_result;
                        exc_addr_q <= alu_result;
                        if (illegal_d || misaligned_d) begin
                            state_q     <= DONE;
                            wb_valid_q  <= 1'b1;
                            wb_we_q     <= 1'b0;
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= illegal_d ? EXC_ILLEGAL : EXC_MISALIGNED;
                        end else if (is_load || is_store) begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store;
                            mem_addr_q  <= {alu_result[31:2], 2'b00};
                            mem_wstrb_q <= is_store ? wstrb_d : 4'b0000;
                            mem_wdata_q <= wdata_d;
                        end else begin
                            state_q    <= DONE;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= reg_we && (rd != 5'd0);
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        if (is_store_q) begin
                            state_q    <= DONE;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                WAIT: begin
                    // Read data beats the timeout when both land on the same cycle.
                    if (mem_rvalid) begin
                        state_q    <= DONE;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= rd_we_q;
                        wb_data_q  <= rdata_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        wb_valid_q  <= 1'b1;
                        wb_we_q     <= 1'b0;
                        exc_valid_q <= 1'b1;
                        exc_cause_q <= EXC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    wb_valid_q  <= 1'b0;
                    wb_we_q     <= 1'b0;
                    exc_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum number of cycles spent in WAIT before the unit reports a bus error.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  the execute-stage result is valid.
REQ-005 in_ready  output  1  the unit can accept an op; high only in IDLE.
REQ-006 alu_result  input  32  ALU output, used as the effective address or passed through as the result.
REQ-007 store_data  input  32  rs2 value for stores.
REQ-008 is_load, is_store  input  1 each  memory op class.
REQ-009 funct3  input  3  access width and sign-extension selector.
REQ-010 rd  input  5  destination register; reg_we  input  1  the op writes rd.
REQ-011 mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wstrb  output  4; mem_wdata  output  32: data-memory request.
REQ-012 mem_gnt  input  1  request accepted; mem_rvalid  input  1  read data valid; mem_rdata  input  32.
REQ-013 wb_valid  output  1; wb_we  output  1; wb_rd  output  5; wb_data  output  32: writeback, single-cycle pulse, no backpressure.
REQ-014 exc_valid  output  1; exc_cause  output  2 (0 misaligned, 1 bus timeout, 2 illegal op); exc_addr  output  32.

Function
REQ-015 The unit SHALL implement four states: IDLE, REQ, WAIT and DONE; an op is accepted when in_valid && in_ready in IDLE, and its inputs are captured.
REQ-016 A non-memory op (is_load=is_store=0) SHALL go to DONE, giving wb_valid 1 cycle after acceptance with wb_data=alu_result and wb_we=reg_we.
REQ-017 The op SHALL be illegal when is_load and is_store are both high, when a load has funct3 in {011, 110, 111}, or when a store has funct3 >= 011; an illegal op goes straight to DONE with exc_cause=2.
REQ-018 The op SHALL be misaligned for a halfword with addr[0]=1 or a word with addr[1:0]!=00; a misaligned op goes straight to DONE with exc_cause=0 and never asserts mem_req.
REQ-019 An aligned memory op SHALL go to REQ, where mem_req is held high until mem_gnt=1 is sampled, with mem_addr={addr[31:2],2'b00} and mem_we=is_store.
REQ-020 Store strobes SHALL be SB 0001<<addr[1:0], SH 0011<<addr[1:0] and SW 1111; store data SHALL be SB {4{byte}}, SH {2{half}} and SW the word; for loads, mem_wstrb=0.
REQ-021 A store SHALL complete on the grant: REQ goes to DONE with wb_we=0.
REQ-022 A load SHALL go to WAIT on the grant and to DONE on mem_rvalid; the byte/half is selected by addr[1:0], with LB/LH sign-extended, LBU/LHU zero-extended and LW passed unchanged.
REQ-023 The WAIT counter SHALL clear on entry to WAIT; if MEM_TIMEOUT cycles elapse without mem_rvalid, the unit goes to DONE with exc_cause=1.
REQ-024 In DONE, wb_valid SHALL be 1 for exactly one cycle, then the unit returns to IDLE; in_ready=0 in REQ, WAIT and DONE.
REQ-025 When exc_valid=1, wb_valid SHALL be 1, wb_we=0 and exc_addr=alu_result.
REQ-026 wb_we SHALL be forced to 0 when rd=0.
REQ-027 mem_rvalid SHALL be ignored outside WAIT, and mem_gnt SHALL be ignored outside REQ.
REQ-028 mem_rvalid arriving in the same cycle as the timeout SHALL win: the data is written back and no exception is raised.

Reset
REQ-029 rst SHALL immediately force IDLE and clear the counter, mem_req, mem_we, mem_wstrb, wb_valid, wb_we and exc_valid to 0; mem_addr, mem_wdata, wb_rd, wb_data, exc_cause and exc_addr SHALL be 0.
REQ-030 Reset during REQ or WAIT SHALL abandon the op with no writeback; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-031 ADD result 0x1234, rd=5, reg_we=1 -> 1 cycle later: wb_valid=1, wb_data=0x1234, wb_we=1, mem_req never asserted.
REQ-032 LB at address 0x103, mem_gnt after 2 cycles, mem_rdata=0x80FF_FFFF -> mem_addr=0x100, wb_data=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
REQ-033 SH at 0x202 with store_data=0xABCD_1234 -> mem_wstrb=1100, mem_wdata=0x1234_1234, then wb_valid=1 with wb_we=0.
REQ-034 LW at 0x301 -> no mem_req, exc_valid=1, exc_cause=0, exc_addr=0x301.
REQ-035 LW granted but mem_rvalid never arrives, MEM_TIMEOUT=4 -> exc_cause=1 after 4 WAIT cycles; a later mem_rvalid produces no wb_valid.
REQ-036 rst pulsed while in WAIT -> outputs are 0 immediately, in_ready=1 after release, and the pending mem_rvalid is ignored.
